// File: rtl/motor_pwm_driver_if.sv
// Command bus from the drive-decision stage into the motor PWM driver.
interface motor_pwm_driver_if;
    logic [2:0] drive_command;
    logic [2:0] multiplier;
    logic       valid;

    modport master (output drive_command, output multiplier, output valid);
    modport slave  (input  drive_command, input  multiplier, input  valid);
endinterface

// File: rtl/motor_pwm_driver.sv
// Two-wheel H-bridge PWM driver: command-to-duty mapping, per-period ramping,
// dead time before direction reversal, immediate stop and a command watchdog.
//
// state  | meaning
// IDLE   | duty 0, waiting for a nonzero target
// RUN    | duty ramps toward target once per PWM period
// DEAD   | duty 0, counting dead time before a direction flip
module motor_pwm_driver #(
    parameter int PWM_PERIOD = 2500,
    parameter int DUTY_FULL  = 2500,
    parameter int DUTY_SLOW  = 1250,
    parameter int DUTY_PIVOT = 1500,
    parameter int RAMP_STEP  = 125,
    parameter int DEAD_TIME  = 50000,
    parameter int WATCHDOG   = 5000000,
    parameter int DW         = $clog2(PWM_PERIOD + 1)
) (
    input  logic              clk,
    input  logic              reset,
    motor_pwm_driver_if.slave cmd_if,
    output logic              left_pwm,
    output logic              left_dir,
    output logic              right_pwm,
    output logic              right_dir,
    output logic [DW-1:0]     left_duty,
    output logic [DW-1:0]     right_duty,
    output logic              timeout
);
    localparam int WDW = $clog2(WATCHDOG + 1);
    localparam int DTW = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
    localparam int PW  = DW + 3;
    localparam logic [DW-1:0]  STEP      = DW'(RAMP_STEP);
    localparam logic [DTW-1:0] DEAD_LOAD = DTW'(DEAD_TIME - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} wheel_state_e;

    logic [DW-1:0]  cnt_q, cnt_d;
    logic [2:0]     cmd_q, cmd_d;
    logic [2:0]     scale_q, scale_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic           timeout_q, timeout_d;
    logic           wrap, force_stop;

    wheel_state_e        st_q [2];
    logic [1:0][DW-1:0]  duty_q;
    logic [1:0]          dir_q;
    logic [1:0][DTW-1:0] dead_q;

    logic [PW-1:0]      base_l, base_r;
    logic [1:0][DW-1:0] tgt, eff, ramp;
    logic [1:0]         tgt_dir;

    function automatic logic is_stop(input logic [2:0] c);
        return (c == 3'd0) || (c >= 3'd6);
    endfunction

    function automatic logic [2:0] eff_scale(input logic [2:0] m);
        return ((m == 3'd0) || (m >= 3'd4)) ? 3'd4 : m;
    endfunction

    function automatic logic [DW-1:0] scaled(input logic [PW-1:0] base, input logic [2:0] scale);
        logic [PW-1:0] prod;
        prod = (base * PW'(scale)) >> 2;
        if (prod > PW'(PWM_PERIOD)) return DW'(PWM_PERIOD);
        return prod[DW-1:0];
    endfunction

    always_comb begin
        wrap      = (cnt_q == DW'(PWM_PERIOD - 1));
        cnt_d     = wrap ? '0 : cnt_q + 1'b1;
        cmd_d     = cmd_if.valid ? cmd_if.drive_command : cmd_q;
        scale_d   = cmd_if.valid ? eff_scale(cmd_if.multiplier) : scale_q;
        wd_d      = '0;
        timeout_d = 1'b0;
        if (!cmd_if.valid) begin
            wd_d      = (wd_q == WDW'(WATCHDOG)) ? wd_q : wd_q + 1'b1;
            timeout_d = timeout_q | (wd_d == WDW'(WATCHDOG));
        end
        // Stop acts on the incoming command so drive is cut on the very next edge.
        force_stop = is_stop(cmd_d) | timeout_d;
    end

    always_comb begin
        base_l  = '0;
        base_r  = '0;
        tgt_dir = 2'b00;
        case (cmd_q)
            3'd1: begin base_l = PW'(DUTY_PIVOT); base_r = PW'(DUTY_PIVOT); tgt_dir = 2'b01; end
            3'd2: begin base_l = PW'(DUTY_SLOW);  base_r = PW'(DUTY_FULL);  end
            3'd3: begin base_l = PW'(DUTY_FULL);  base_r = PW'(DUTY_FULL);  end
            3'd4: begin base_l = PW'(DUTY_FULL);  base_r = PW'(DUTY_SLOW);  end
            3'd5: begin base_l = PW'(DUTY_PIVOT); base_r = PW'(DUTY_PIVOT); tgt_dir = 2'b10; end
            default: ;
        endcase
        tgt[0] = scaled(base_l, scale_q);
        tgt[1] = scaled(base_r, scale_q);
    end

    // A pending reversal ramps toward zero first.
    always_comb begin
        eff  = '0;
        ramp = '0;
        for (int w = 0; w < 2; w++) begin
            eff[w] = (tgt_dir[w] != dir_q[w]) ? '0 : tgt[w];
            if (duty_q[w] < eff[w])
                ramp[w] = ((eff[w] - duty_q[w]) > STEP) ? duty_q[w] + STEP : eff[w];
            else
                ramp[w] = ((duty_q[w] - eff[w]) > STEP) ? duty_q[w] - STEP : eff[w];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            cmd_q     <= 3'd0;
            scale_q   <= 3'd4;
            wd_q      <= '0;
            timeout_q <= 1'b0;
            duty_q    <= '0;
            dir_q     <= 2'b00;
            dead_q    <= '0;
            st_q[0]   <= S_IDLE;
            st_q[1]   <= S_IDLE;
        end else begin
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            scale_q   <= scale_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
            for (int w = 0; w < 2; w++) begin
                if (force_stop) begin
                    st_q[w]   <= S_IDLE;
                    duty_q[w] <= '0;
                end else begin
                    case (st_q[w])
                        S_IDLE: begin
                            if (wrap && (tgt[w] != '0)) begin
                                if (tgt_dir[w] == dir_q[w]) begin
                                    st_q[w]   <= S_RUN;
                                    duty_q[w] <= ramp[w];
                                end else begin
                                    st_q[w]   <= S_DEAD;
                                    dead_q[w] <= DEAD_LOAD;
                                end
                            end
                        end
                        S_RUN: begin
                            if (wrap) begin
                                duty_q[w] <= ramp[w];
                                if (ramp[w] == '0) begin
                                    if (tgt[w] == '0) begin
                                        st_q[w] <= S_IDLE;
                                    end else if (tgt_dir[w] != dir_q[w]) begin
                                        st_q[w]   <= S_DEAD;
                                        dead_q[w] <= DEAD_LOAD;
                                    end
                                end
                            end
                        end
                        S_DEAD: begin
                            if (tgt[w] == '0) begin
                                st_q[w] <= S_IDLE;
                            end else if (tgt_dir[w] == dir_q[w]) begin
                                st_q[w] <= S_RUN;
                            end else if (dead_q[w] == '0) begin
                                dir_q[w] <= ~dir_q[w];
                                st_q[w]  <= S_RUN;
                            end else begin
                                dead_q[w] <= dead_q[w] - 1'b1;
                            end
                        end
                        default: st_q[w] <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign left_pwm   = (cnt_q < duty_q[0]);
    assign right_pwm  = (cnt_q < duty_q[1]);
    assign left_dir   = dir_q[0];
    assign right_dir  = dir_q[1];
    assign left_duty  = duty_q[0];
    assign right_duty = duty_q[1];
    assign timeout    = timeout_q;
endmodule
